ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  PS/2 device-to-host receiver with glitch filter, frame timeout and a scancode FIFO.
//  Next-generation keyboard peripheral: single clock domain, fully synchronous.
//  Validated bytes are buffered so the CPU drains them at its own pace.
//  Sits between the PS/2 pins and the CPU I/O bus / interrupt controller.
// PARAMETERS
//  FILTER_LEN   4      consecutive identical samples needed to change a filtered line (>=2)
//  DEPTH        8      FIFO entries (power of two, >=2)
//  TIMEOUT_CYC  10000  clk cycles without a filtered ps_clk fall before an open frame is aborted
// PORTS
//  clk          in   1  system clock; sole clock, all logic on posedge
//  rst          in   1  synchronous reset, active-high
//  ps_clk       in   1  raw PS/2 clock pin (asynchronous)
//  ps_data      in   1  raw PS/2 data pin (asynchronous)
//  rd_en        in   1  pop request; effective only while valid=1
//  clr_ovf      in   1  clears the sticky overflow flag
//  data_out     out  8  FIFO head (show-ahead); 8'h00 when empty
//  valid        out  1  FIFO non-empty
//  count        out  $clog2(DEPTH)+1  current FIFO occupancy
//  irq          out  1  one-cycle pulse per byte written to the FIFO
//  overflow     out  1  sticky: a good frame was dropped because the FIFO was full
//  err_parity   out  1  one-cycle pulse: frame dropped, bad parity/start/stop
//  err_timeout  out  1  one-cycle pulse: frame aborted by timeout
// BEHAVIOUR
//  Reset: FSM IDLE, bit_cnt=0, FIFO empty, count=0, data_out=0, valid/irq/overflow/err_*=0,
//   sync and filter registers preset to 1 (idle-high bus). Reset mid-frame discards the frame.
//  Input path: 2-FF synchroniser per pin, then filter: output flips only after FILTER_LEN
//   consecutive synced samples differ from it. fall = filt_clk 1->0 (one-cycle strobe).
//  Sampling: on fall, shift filt_data into an 11-bit shifter, LSB first.
//  FSM IDLE: on fall -> RECV, bit_cnt=1, timeout counter cleared.
//  FSM RECV: each fall increments bit_cnt, clears the timeout counter; fall with bit_cnt==10
//   -> CHECK. No fall for TIMEOUT_CYC cycles -> IDLE, err_timeout pulse, partial frame discarded.
//  FSM CHECK (one cycle): good = start==0 & stop==1 & ^{data,parity}==1 (odd parity).
//   good & (not full or rd_en&valid same cycle) -> write, irq pulse this cycle.
//   good & full & no pop -> drop, overflow<=1. not good -> drop, err_parity pulse. Then IDLE.
//  Latency: cycle after the 11th fall = CHECK/write; valid and data_out update the next cycle.
//  FIFO: circular, wrap-around pointers, extra count bit. Pop (rd_en&valid) advances head,
//   visible next cycle. rd_en while empty ignored. Simultaneous push+pop: both occur,
//   count unchanged, including when full.
//  overflow: set has priority over clr_ovf in the same cycle.
//  A fall during CHECK belongs to no frame and is ignored.
// TESTING
//  1. Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), 80us bit period -> irq pulse,
//     valid=1, data_out=8'h1C, count=1; rd_en one cycle -> valid=0, count=0.
//  2. Frame 0x1C with parity=1 -> err_parity pulse, no irq, count unchanged.
//  3. 5 bits then bus idle -> err_timeout exactly TIMEOUT_CYC cycles after 5th fall;
//     next clean 0xF0 frame received correctly.
//  4. DEPTH+1 frames 0x01..0x09, no reads -> count=8, overflow=1, data_out=0x01;
//     clr_ovf -> overflow=0; pop during 10th frame CHECK -> no overflow, count stays 8.
//  5. ps_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no bit sampled, frame decodes OK.
//  6. rst asserted after bit 6 of a frame -> all outputs 0, FIFO empty; next frame decodes OK.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver. Pins are synchronised and glitch-filtered, frames are
// assembled by a timeout-guarded FSM, and good bytes go to a show-ahead FIFO for the CPU.
module ps2_rx_fifo #(
   parameter int FILTER_LEN  = 4,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 10000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ps_clk,
   input  logic                     ps_data,
   input  logic                     rd_en,
   input  logic                     clr_ovf,
   output logic [7:0]               data_out,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     irq,
   output logic                     overflow,
   output logic                     err_parity,
   output logic                     err_timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   // Frame layout in the shifter: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
   function automatic logic frame_good(input logic [10:0] f);
      return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
   endfunction

   logic [1:0]    sync1_q, sync2_q, filt_q;
   logic [FW-1:0] flt_cnt_q [2];
   logic          filt_clk_prev_q;
   logic          fall_s;

   state_t        state_q;
   logic [3:0]    bit_cnt_q;
   logic [TW-1:0] tmo_q;
   logic [10:0]   shift_q;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          valid_q, irq_q, overflow_q, err_parity_q, err_timeout_q;
   logic          good_s, full_s, pop_s, push_s;

   // Bit 0 carries ps_clk, bit 1 carries ps_data; both idle high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q         <= 2'b11;
         sync2_q         <= 2'b11;
         filt_q          <= 2'b11;
         filt_clk_prev_q <= 1'b1;
         for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
      end else begin
         sync1_q         <= {ps_data, ps_clk};
         sync2_q         <= sync1_q;
         filt_clk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
               if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                  filt_q[i]    <= sync2_q[i];
                  flt_cnt_q[i] <= '0;
               end else begin
                  flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
               end
            end else begin
               flt_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign fall_s = filt_clk_prev_q & ~filt_q[0];

   always_comb begin
      good_s   = frame_good(shift_q);
      full_s   = (count_q == (AW+1)'(DEPTH));
      pop_s    = rd_en & valid_q;
      push_s   = (state_q == S_CHECK) & good_s & (~full_s | pop_s);
      wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // The head is registered, so a byte landing in the new head slot bypasses memory.
      if (count_d == '0) begin
         data_out_d = 8'h00;
      end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         data_out_d = shift_q[8:1];
      end else begin
         data_out_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= shift_q[8:1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= 4'd0;
         tmo_q         <= '0;
         shift_q       <= 11'h000;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         data_out_q    <= 8'h00;
         valid_q       <= 1'b0;
         irq_q         <= 1'b0;
         overflow_q    <= 1'b0;
         err_parity_q  <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         data_out_q    <= data_out_d;
         valid_q       <= (count_d != '0);
         irq_q         <= push_s;
         err_parity_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         if ((state_q == S_CHECK) && good_s && full_s && !pop_s) begin
            overflow_q <= 1'b1;
         end else if (clr_ovf) begin
            overflow_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (fall_s) begin
                  state_q   <= S_RECV;
                  bit_cnt_q <= 4'd1;
                  tmo_q     <= '0;
                  shift_q   <= {filt_q[1], shift_q[10:1]};
               end
            end
            S_RECV: begin
               if (fall_s) begin
                  tmo_q     <= '0;
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  shift_q   <= {filt_q[1], shift_q[10:1]};
                  if (bit_cnt_q == 4'd10) begin
                     state_q <= S_CHECK;
                  end
               end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                  state_q       <= S_IDLE;
                  bit_cnt_q     <= 4'd0;
                  tmo_q         <= '0;
                  err_timeout_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_CHECK: begin
               state_q      <= S_IDLE;
               bit_cnt_q    <= 4'd0;
               err_parity_q <= ~good_s;
            end
            default: begin
               state_q   <= S_IDLE;
               bit_cnt_q <= 4'd0;
            end
         endcase
      end
   end

   assign data_out    = data_out_q;
   assign valid       = valid_q;
   assign count       = count_q;
   assign irq         = irq_q;
   assign overflow    = overflow_q;
   assign err_parity  = err_parity_q;
   assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with a scaled-down bit period
// and timeout so the whole run stays short.
module tb_ps2_rx_fifo;
   localparam int HALF = 20;
   localparam int TMO  = 300;

   logic       clk = 1'b0;
   logic       rst, ps_clk, ps_data, rd_en, clr_ovf;
   logic [7:0] data_out;
   logic       valid, irq, overflow, err_parity, err_timeout;
   logic [3:0] count;

   int n_cmp = 0;
   int n_err = 0;
   int irq_seen = 0;
   int perr_seen = 0;
   int tmo_seen = 0;

   ps2_rx_fifo #(.FILTER_LEN(4), .DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .ps_clk(ps_clk), .ps_data(ps_data), .rd_en(rd_en),
      .clr_ovf(clr_ovf), .data_out(data_out), .valid(valid), .count(count), .irq(irq),
      .overflow(overflow), .err_parity(err_parity), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Pulse counters: each high cycle is counted once, so a stretched pulse shows up too.
   always @(negedge clk) begin
      if (irq === 1'b1) irq_seen++;
      if (err_parity === 1'b1) perr_seen++;
      if (err_timeout === 1'b1) tmo_seen++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input bit glitch, input bit pop_chk);
      ps_data = b;
      ps_clk  = 1'b1;
      for (int i = 0; i < HALF; i++) begin
         tick(1);
         if (glitch && i == 5) ps_clk = 1'b0;
         if (glitch && i == 8) ps_clk = 1'b1;
      end
      ps_clk = 1'b0;
      // The 11th fall reaches the FSM 7 edges later (2 sync + 4 filter + 1), so CHECK is edge 7..8.
      for (int i = 0; i < HALF; i++) begin
         tick(1);
         if (pop_chk && i == 6) rd_en = 1'b1;
         if (pop_chk && i == 7) rd_en = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitch,
                             input bit pop_chk);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i], glitch && (i == 4), pop_chk && (i == 10));
      ps_clk  = 1'b1;
      ps_data = 1'b1;
      tick(HALF);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ps_clk = 1'b1; ps_data = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data_out); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if ({valid, irq, overflow, err_parity, err_timeout} !== 5'b00000) begin
         n_err++; $display("FAIL reset_flags got %b want 00000", {valid, irq, overflow, err_parity, err_timeout});
      end
   endtask

   task automatic test_basic();
      int i0;
      i0 = irq_seen;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (irq_seen - i0 !== 1) begin n_err++; $display("FAIL basic_irq got %0d want 1", irq_seen - i0); end
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", valid); end
      n_cmp++; if (data_out !== 8'h1C) begin n_err++; $display("FAIL basic_data got %h want 1c", data_out); end
      n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", count); end
      pop_one();
      n_cmp++; if ({valid, count} !== 5'b0_0000) begin n_err++; $display("FAIL basic_pop got v=%b c=%0d want 0/0", valid, count); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL basic_empty_data got %h want 00", data_out); end
      pop_one();
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL empty_pop_count got %0d want 0", count); end
   endtask

   task automatic test_parity();
      int i0, p0;
      i0 = irq_seen; p0 = perr_seen;
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (perr_seen - p0 !== 1) begin n_err++; $display("FAIL parity_err got %0d want 1", perr_seen - p0); end
      n_cmp++; if (irq_seen - i0 !== 0) begin n_err++; $display("FAIL parity_irq got %0d want 0", irq_seen - i0); end
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL parity_count got %0d want 0", count); end
   endtask

   task automatic test_timeout();
      int t0, lat;
      t0 = tmo_seen;
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      ps_data = 1'b1; ps_clk = 1'b1;
      tick(HALF);
      ps_clk = 1'b0;
      lat = -1;
      for (int k = 1; k <= TMO + 100; k++) begin
         tick(1);
         if (k == HALF) ps_clk = 1'b1;
         if (err_timeout === 1'b1) begin
            lat = k;
            break;
         end
      end
      n_cmp++; if (lat !== TMO + 7) begin n_err++; $display("FAIL timeout_latency got %0d want %0d", lat, TMO + 7); end
      tick(1);
      n_cmp++; if (tmo_seen - t0 !== 1) begin n_err++; $display("FAIL timeout_pulse got %0d want 1", tmo_seen - t0); end
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (data_out !== 8'hF0 || count !== 4'd1) begin
         n_err++; $display("FAIL timeout_next got %h/%0d want f0/1", data_out, count);
      end
      pop_one();
   endtask

   task automatic test_glitch();
      int p0;
      p0 = perr_seen;
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (data_out !== 8'h5A || count !== 4'd1) begin
         n_err++; $display("FAIL glitch_data got %h/%0d want 5a/1", data_out, count);
      end
      n_cmp++; if (perr_seen - p0 !== 0) begin n_err++; $display("FAIL glitch_perr got %0d want 0", perr_seen - p0); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q [8];
      int i0;
      exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
      i0 = irq_seen;
      for (int d = 1; d <= 8; d++) send_frame(8'(d), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin
         n_err++; $display("FAIL full_state got %0d/%b want 8/0", count, overflow);
      end
      send_frame(8'h09, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_cmp++; if (data_out !== 8'h01) begin n_err++; $display("FAIL ovf_head got %h want 01", data_out); end
      n_cmp++; if (irq_seen - i0 !== 8) begin n_err++; $display("FAIL ovf_irqs got %0d want 8", irq_seen - i0); end
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", overflow); end
      send_frame(8'h0A, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (count !== 4'd8 || overflow !== 1'b0) begin
         n_err++; $display("FAIL pushpop_full got %0d/%b want 8/0", count, overflow);
      end
      n_cmp++; if (data_out !== 8'h02) begin n_err++; $display("FAIL pushpop_head got %h want 02", data_out); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (data_out !== exp_q[i]) begin
            n_err++; $display("FAIL drain_%0d got %h want %h", i, data_out, exp_q[i]);
         end
         pop_one();
      end
      n_cmp++; if (valid !== 1'b0 || count !== 4'd0) begin
         n_err++; $display("FAIL drain_empty got %b/%0d want 0/0", valid, count);
      end
   endtask

   task automatic test_reset_mid();
      int i0, p0;
      send_frame(8'h77, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
      ps_clk = 1'b1;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_cmp++; if ({data_out, valid, count, overflow} !== 14'h0000) begin
         n_err++; $display("FAIL midrst_outs got %h/%b/%0d/%b want 0", data_out, valid, count, overflow);
      end
      i0 = irq_seen; p0 = perr_seen;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (data_out !== 8'h3C || count !== 4'd1) begin
         n_err++; $display("FAIL midrst_next got %h/%0d want 3c/1", data_out, count);
      end
      n_cmp++; if (irq_seen - i0 !== 1 || perr_seen - p0 !== 0) begin
         n_err++; $display("FAIL midrst_pulses got irq %0d perr %0d want 1/0", irq_seen - i0, perr_seen - p0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_timeout();
      test_glitch();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
